// File: rtl/sklansky_pkg.sv
// rtl/sklansky_pkg.sv - command encodings, FSM states and widths shared by the Sklansky accumulator
package sklansky_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP    = 2'b00,
    CMD_LOAD_A = 2'b01,
    CMD_ADD    = 2'b10,
    CMD_ACC    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/sklansky_prefix_add.sv
// rtl/sklansky_prefix_add.sv - combinational WIDTH-bit Sklansky (divide-and-conquer) prefix adder with carry-in
module sklansky_prefix_add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);

  // g/p[l][i] hold the group generate/propagate of bits [block_start..i] after level l
  logic [WIDTH-1:0] g [0:LEVELS];
  logic [WIDTH-1:0] p [0:LEVELS];
  logic [WIDTH:0]   c;

  always_comb begin
    int j;
    j = 0;
    g[0] = a & b;
    p[0] = a ^ b;
    for (int l = 1; l <= LEVELS; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> (l - 1)) & 1) == 1) begin
          // upper half of each 2^l block fans in from the top bit of the lower half
          j = ((i >> (l - 1)) << (l - 1)) - 1;
          g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][j]);
          p[l][i] = p[l-1][i] & p[l-1][j];
        end else begin
          g[l][i] = g[l-1][i];
          p[l][i] = p[l-1][i];
        end
      end
    end
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[LEVELS][i] | (p[LEVELS][i] & cin);
    end
  end

  assign sum  = p[0] ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/sklansky_acc_controller.sv
// rtl/sklansky_acc_controller.sv - 3-state add/accumulate controller around one Sklansky prefix adder
// Optional ACC saturation on carry-out: define SKLANSKY_ACC_SAT_EN.
module sklansky_acc_controller
  import sklansky_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CMD_W = sklansky_pkg::CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             out_valid,
  output logic [WIDTH-1:0] acc_a
);

  state_e           state, state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             cin_reg;
  logic             is_acc;
  logic [WIDTH-1:0] sum_res;
  logic             sum_cout;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             op_start;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign acc_a     = a_reg;
  assign accept    = in_valid && in_ready;
  assign op_start  = accept && ((cmd == CMD_ADD) || (cmd == CMD_ACC));

  sklansky_prefix_add #(.WIDTH(WIDTH)) u_add (
    .a    (a_reg),
    .b    (b_reg),
    .cin  (cin_reg),
    .sum  (sum_res),
    .cout (sum_cout)
  );

`ifdef SKLANSKY_ACC_SAT_EN
  assign result = (is_acc && sum_cout) ? {WIDTH{1'b1}} : sum_res;
`else
  assign result = sum_res;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (op_start) state_next = CALC;
      CALC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      cin_reg <= 1'b0;
      is_acc  <= 1'b0;
      out     <= '0;
      cout    <= 1'b0;
    end else begin
      if (accept) begin
        // unknown or NOP commands fall through to default and change nothing
        case (cmd)
          CMD_LOAD_A: a_reg <= in;
          CMD_ADD, CMD_ACC: begin
            b_reg   <= in;
            cin_reg <= cin;
            is_acc  <= (cmd == CMD_ACC);
          end
          default: ;
        endcase
      end
      if (state == CALC) begin
        out  <= result;
        cout <= sum_cout;
        if (is_acc) a_reg <= result;
      end
    end
  end

endmodule

// File: doc/sklansky_acc_controller.md
SKLANSKY_ACC_CONTROLLER -- requirements
Module: sklansky_acc_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 16; operand/result width in bits, legal range 4..64.
REQ-002 SHALL have parameter CMD_W, default 2; command field width, fixed at 2.
REQ-003 SHALL have port clk, input, 1; single rising-edge clock.
REQ-004 SHALL have port rst, input, 1; asynchronous, active-high reset.
REQ-005 SHALL have port in, input, WIDTH; operand B, or the A load value.
REQ-006 SHALL have port cmd, input, CMD_W; 00 NOP, 01 LOAD_A, 10 ADD, 11 ACC.
REQ-007 SHALL have port cin, input, 1; carry-in for ADD/ACC.
REQ-008 SHALL have port in_valid, input, 1; in/cmd/cin qualified.
REQ-009 SHALL have port in_ready, output, 1; block accepts a command this cycle.
REQ-010 SHALL have port out, output, WIDTH; registered sum.
REQ-011 SHALL have port cout, output, 1; registered carry-out.
REQ-012 SHALL have port out_valid, output, 1; out/cout valid, one-cycle pulse.
REQ-013 SHALL have port acc_a, output, WIDTH; current contents of register A.

Function
REQ-014 Transfer SHALL occur on a rising edge where in_valid && in_ready; no command is acted on otherwise.
REQ-015 FSM SHALL have states IDLE, CALC, DONE; in_ready=1 only in IDLE.
REQ-016 LOAD_A accepted: A <= in on that edge, stays IDLE, no out_valid.
REQ-017 NOP accepted: no state change, no out_valid.
REQ-018 ADD/ACC accepted: capture B=in, cin, cmd; go IDLE->CALC.
REQ-019 CALC: evaluate {cout,out} = A + B + cin over a WIDTH-bit Sklansky prefix tree; register the result; go to DONE.
REQ-020 DONE: out_valid=1 for exactly one cycle; go to IDLE. Latency is 2 edges from accept to out_valid high.
REQ-021 ACC: A <= out on the CALC->DONE edge. ADD leaves A unchanged.
REQ-022 out/cout SHALL hold their last value until the next result; they are not cleared when out_valid drops.
REQ-023 Wrap-around: the sum SHALL be modulo 2^WIDTH, with cout = bit WIDTH, unless REQ-029 applies.
REQ-024 The next command may be accepted in the cycle after DONE; peak throughput is 1 op per 3 cycles.
REQ-025 Illegal/unknown cmd bits (X) SHALL be treated as NOP in synthesis; the bench flags them as an error.

Reset
REQ-026 rst high SHALL immediately force state=IDLE, A=0, out=0, cout=0, out_valid=0, in_ready=1, independent of clk.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation: no out_valid, and A is not updated by the aborted ACC.
REQ-028 On the first edge after rst deasserts, the block SHALL accept a command.

Configuration
REQ-029 Macro SKLANSKY_ACC_SAT_EN defined: ACC with carry-out SHALL load A and out with all-ones, with cout=1; ADD is unaffected.
REQ-030 Macro SKLANSKY_ACC_SAT_EN undefined: ACC wraps per REQ-023; no saturation logic is present.

Structure
REQ-031 Package sklansky_pkg SHALL hold the cmd encodings (CMD_NOP/LOAD_A/ADD/ACC), the FSM state enum and the CMD_W constant.
REQ-032 Sub-module sklansky_prefix_add #(WIDTH) SHALL be purely combinational (a, b, cin -> sum, cout), with log2(WIDTH) prefix levels and one instance.

Verification
REQ-033 WIDTH=16: LOAD_A 0x1234, then ADD in=0x0F0F cin=0 -> out=0x2143, cout=0, out_valid 2 cycles after accept, A still 0x1234.
REQ-034 WIDTH=16: LOAD_A 0xFFFF, then ADD in=0x0000 cin=1 -> out=0x0000, cout=1.
REQ-035 WIDTH=8: LOAD_A 0x10, then ACC in=0x05 three times -> outputs 0x15, 0x1A, 0x1F; acc_a=0x1F.
REQ-036 WIDTH=8: LOAD_A 0xF0, then ACC in=0x20 -> out=0x10, cout=1 without the macro; out=0xFF, cout=1 with SKLANSKY_ACC_SAT_EN.
REQ-037 Hold in_valid high with ADD continuously -> in_ready low in CALC/DONE; exactly one result per 3 cycles; no command dropped.
REQ-038 Assert rst mid-CALC of an ACC -> no out_valid, acc_a=0, out=0; the next command is accepted on the first edge after release.
